// File: rtl/axis_check_module_if.sv
// AXI-Stream beat bundle carrying the length-tagged test frames into the checker.
// The master drives the beat and the slave returns ready.
interface axis_check_module_if;
   logic [63:0] tdata;
   logic [31:0] tuser;
   logic [7:0]  tkeep;
   logic        tlast;
   logic        tvalid;
   logic        tready;

   modport master (output tdata, output tuser, output tkeep, output tlast, output tvalid,
                   input tready);
   modport slave  (input tdata, input tuser, input tkeep, input tlast, input tvalid,
                   output tready);
endinterface

// File: rtl/axis_check_module.sv
// Sink-side checker for numbered AXI-Stream test frames.
// It checks payload pattern, tkeep shape, length and sequence continuity.
module axis_check_module #(
   parameter logic [15:0] P_MAX_LEN      = 16'd1472,
   parameter int          P_READY_PERIOD = 0
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   axis_check_module_if.slave         s_axis,
   input  logic                       i_clear,
   output logic [31:0]                o_frame_cnt,
   output logic [31:0]                o_err_cnt,
   output logic [3:0]                 o_err_flags,
   output logic                       o_pass
);

   localparam int          MAX_BEATS   = (int'(P_MAX_LEN) + 7) / 8 + 1;
   localparam logic [15:0] MAX_BEATS_W = 16'(MAX_BEATS);
   localparam bit          RDY_EN      = (P_READY_PERIOD != 0);
   localparam logic [15:0] RDY_LAST    = RDY_EN ? 16'(P_READY_PERIOD - 1) : 16'd0;

   localparam int BIT_KEEP = 3;
   localparam int BIT_SEQ  = 2;
   localparam int BIT_LEN  = 1;
   localparam int BIT_DATA = 0;

   typedef enum logic [1:0] {IDLE, DATA, CHECK} state_t;

   state_t      state_q, state_d;
   logic [15:0] len_q, len_d;
   logic [31:0] seq_q, seq_d;
   logic [15:0] beat_q, beat_d;
   logic        discard_q, discard_d;
   logic [3:0]  frame_err_q, frame_err_d;
   logic        drop_q, drop_d;
   logic [31:0] exp_seq_q, exp_seq_d;
   logic        locked_q, locked_d;
   logic [15:0] rdy_cnt_q, rdy_cnt_d;
   logic        tready_q, tready_d;
   logic [31:0] frame_cnt_q, frame_cnt_d;
   logic [31:0] err_cnt_q, err_cnt_d;
   logic [3:0]  err_flags_q, err_flags_d;
   logic        pass_q, pass_d;

   logic        hs;
   logic        first;
   logic        gap;
   logic [15:0] cur_len;
   logic [31:0] cur_seq;
   logic [15:0] cur_idx;
   logic        cur_disc;
   logic [63:0] exp_word;
   logic [16:0] exp_beats;
   logic [7:0]  last_keep;
   logic [3:0]  beat_err;
   logic        tuser_unused;

   assign tuser_unused = ^s_axis.tuser[31:16];

   // Per-beat checks; on the first beat the length and sequence come straight from the bus.
   always_comb begin
      hs        = s_axis.tvalid & tready_q;
      first     = (state_q == IDLE);
      cur_len   = first ? s_axis.tuser[15:0]  : len_q;
      cur_seq   = first ? s_axis.tdata[63:32] : seq_q;
      cur_idx   = first ? 16'd0 : beat_q;
      cur_disc  = first ? 1'b0  : discard_q;
      exp_word  = {cur_seq, 16'd0, cur_idx};
      exp_beats = ({1'b0, cur_len} + 17'd7) >> 3;
      last_keep = (cur_len[2:0] == 3'd0) ? 8'hFF : ((8'd1 << cur_len[2:0]) - 8'd1);
      beat_err  = 4'b0000;

      if (!cur_disc) begin
         for (int i = 0; i < 8; i++) begin
            if (s_axis.tkeep[i] && (s_axis.tdata[8*i +: 8] != exp_word[8*i +: 8])) begin
               beat_err[BIT_DATA] = 1'b1;
            end
         end
         if (s_axis.tlast ? (s_axis.tkeep != last_keep) : (s_axis.tkeep != 8'hFF)) begin
            beat_err[BIT_KEEP] = 1'b1;
         end
      end

      if (first && ((cur_len == 16'd0) || (cur_len > P_MAX_LEN))) begin
         beat_err[BIT_LEN] = 1'b1;
      end
      if (s_axis.tlast && (({1'b0, cur_idx} + 17'd1) != exp_beats)) begin
         beat_err[BIT_LEN] = 1'b1;
      end
      if (!s_axis.tlast && (cur_idx >= MAX_BEATS_W)) begin
         beat_err[BIT_LEN] = 1'b1;
      end
      if (first && locked_q && (s_axis.tdata[63:32] != exp_seq_q)) begin
         beat_err[BIT_SEQ] = 1'b1;
      end
   end

   // Next-state logic for the frame FSM, statistics and the ready throttle.
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      seq_d       = seq_q;
      beat_d      = beat_q;
      discard_d   = discard_q;
      frame_err_d = frame_err_q;
      drop_d      = drop_q;
      exp_seq_d   = exp_seq_q;
      locked_d    = locked_q;
      rdy_cnt_d   = rdy_cnt_q;
      frame_cnt_d = frame_cnt_q;
      err_cnt_d   = err_cnt_q;
      err_flags_d = err_flags_q;
      gap         = 1'b0;

      case (state_q)
         IDLE: begin
            if (hs) begin
               len_d       = cur_len;
               seq_d       = cur_seq;
               beat_d      = 16'd1;
               discard_d   = 1'b0;
               drop_d      = 1'b0;
               frame_err_d = beat_err;
               state_d     = s_axis.tlast ? CHECK : DATA;
            end
         end
         DATA: begin
            if (hs) begin
               frame_err_d = frame_err_q | beat_err;
               if (s_axis.tlast) begin
                  state_d = CHECK;
               end else if (beat_q >= MAX_BEATS_W) begin
                  discard_d = 1'b1;
               end else begin
                  beat_d = beat_q + 16'd1;
               end
            end
         end
         CHECK: begin
            state_d = IDLE;
            if (!drop_q) begin
               frame_cnt_d = frame_cnt_q + 32'd1;
               if ((frame_err_q != 4'b0000) && (err_cnt_q != 32'hFFFF_FFFF)) begin
                  err_cnt_d = err_cnt_q + 32'd1;
               end
               err_flags_d = err_flags_q | frame_err_q;
               exp_seq_d   = seq_q + 32'd1;
               locked_d    = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Clear wins over a same-cycle CHECK and poisons whatever frame is in flight.
      if (i_clear) begin
         frame_cnt_d = 32'd0;
         err_cnt_d   = 32'd0;
         err_flags_d = 4'b0000;
         locked_d    = 1'b0;
         drop_d      = 1'b1;
      end

      if (RDY_EN && hs) begin
         gap       = (rdy_cnt_q == RDY_LAST);
         rdy_cnt_d = gap ? 16'd0 : rdy_cnt_q + 16'd1;
      end

      tready_d = (state_d != CHECK) && !gap;
      pass_d   = (frame_cnt_d != 32'd0) && (err_flags_d == 4'b0000);
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q     <= IDLE;
         len_q       <= 16'd0;
         seq_q       <= 32'd0;
         beat_q      <= 16'd0;
         discard_q   <= 1'b0;
         frame_err_q <= 4'b0000;
         drop_q      <= 1'b0;
         exp_seq_q   <= 32'd0;
         locked_q    <= 1'b0;
         rdy_cnt_q   <= 16'd0;
         tready_q    <= 1'b0;
         frame_cnt_q <= 32'd0;
         err_cnt_q   <= 32'd0;
         err_flags_q <= 4'b0000;
         pass_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         seq_q       <= seq_d;
         beat_q      <= beat_d;
         discard_q   <= discard_d;
         frame_err_q <= frame_err_d;
         drop_q      <= drop_d;
         exp_seq_q   <= exp_seq_d;
         locked_q    <= locked_d;
         rdy_cnt_q   <= rdy_cnt_d;
         tready_q    <= tready_d;
         frame_cnt_q <= frame_cnt_d;
         err_cnt_q   <= err_cnt_d;
         err_flags_q <= err_flags_d;
         pass_q      <= pass_d;
      end
   end

   assign s_axis.tready = tready_q;
   assign o_frame_cnt   = frame_cnt_q;
   assign o_err_cnt     = err_cnt_q;
   assign o_err_flags   = err_flags_q;
   assign o_pass        = pass_q;

endmodule

// File: tb/tb_axis_check_module.sv
// Directed bench for axis_check_module: one always-ready instance and one
// instance throttled with a ready gap every 4 beats.
module tb_axis_check_module;

   logic        i_clk   = 1'b0;
   logic        i_rst   = 1'b1;
   logic        i_clear = 1'b0;

   logic [31:0] frame_cnt0, err_cnt0, frame_cnt4, err_cnt4;
   logic [3:0]  flags0, flags4;
   logic        pass0, pass4;

   int n_checks = 0;
   int n_fail   = 0;

   axis_check_module_if s0 ();
   axis_check_module_if s4 ();

   axis_check_module dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .s_axis      (s0.slave),
      .i_clear     (i_clear),
      .o_frame_cnt (frame_cnt0),
      .o_err_cnt   (err_cnt0),
      .o_err_flags (flags0),
      .o_pass      (pass0)
   );

   axis_check_module #(.P_READY_PERIOD(4)) dut4 (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .s_axis      (s4.slave),
      .i_clear     (i_clear),
      .o_frame_cnt (frame_cnt4),
      .o_err_cnt   (err_cnt4),
      .o_err_flags (flags4),
      .o_pass      (pass4)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_stats(input string tag, input logic [31:0] fc, input logic [31:0] ec,
                              input logic [3:0] fl, input logic ps);
      check_output({tag, ".frame_cnt"}, frame_cnt0, fc);
      check_output({tag, ".err_cnt"},   err_cnt0,   ec);
      check_output({tag, ".err_flags"}, flags0,     fl);
      check_output({tag, ".pass"},      pass0,      ps);
   endtask

   // Present one beat on the always-ready port, wait (bounded) for ready, then let it be taken.
   task automatic push_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                            input logic [15:0] len);
      int n;
      n = 0;
      s0.tdata  = d;
      s0.tkeep  = k;
      s0.tlast  = l;
      s0.tuser  = {16'hA5A5, len};
      s0.tvalid = 1'b1;
      while (s0.tready !== 1'b1 && n < 50) begin
         @(negedge i_clk);
         n++;
      end
      if (s0.tready !== 1'b1) check_output("ready_timeout", s0.tready, 64'd1);
      @(posedge i_clk);
      @(negedge i_clk);
      s0.tvalid = 1'b0;
      s0.tlast  = 1'b0;
   endtask

   // nbeats=0 derives ceil(len/8); keep_last<0 means 8'hFF; bad_beat<0 means no corruption.
   task automatic send_frame(input logic [31:0] seq, input logic [15:0] len, input int nbeats,
                             input int keep_last, input int bad_beat, input int bad_byte,
                             input bit clr_at_check);
      int          nb;
      logic [63:0] w;
      logic [7:0]  k;
      nb = (nbeats > 0) ? nbeats : (int'(len) + 7) / 8;
      if (nb == 0) nb = 1;
      for (int b = 0; b < nb; b++) begin
         w = {seq, 32'(b)};
         if (b == bad_beat) w[bad_byte*8 +: 8] = ~w[bad_byte*8 +: 8];
         k = (b == nb - 1 && keep_last >= 0) ? 8'(keep_last) : 8'hFF;
         push_beat(w, k, (b == nb - 1), len);
      end
      if (clr_at_check) begin
         i_clear = 1'b1;
         @(negedge i_clk);
         i_clear = 1'b0;
      end else begin
         @(negedge i_clk);
      end
      @(negedge i_clk);
   endtask

   task automatic pulse_clear();
      i_clear = 1'b1;
      @(negedge i_clk);
      i_clear = 1'b0;
      @(negedge i_clk);
   endtask

   initial begin
      logic [14:0] ready_seen;
      int          k4;

      s0.tdata = '0; s0.tuser = '0; s0.tkeep = '0; s0.tlast = 1'b0; s0.tvalid = 1'b0;
      s4.tdata = '0; s4.tuser = '0; s4.tkeep = '0; s4.tlast = 1'b0; s4.tvalid = 1'b0;
      ready_seen = '0;

      // Reset state
      #3 i_rst = 1'b0;
      @(negedge i_clk);
      check_output("rst.tready", s0.tready, 64'd0);
      check_stats("rst", 32'd0, 32'd0, 4'b0000, 1'b0);
      i_rst = 1'b1;
      @(negedge i_clk);
      check_output("rst.tready_after", s0.tready, 64'd1);

      // Three good 64-byte frames, seq 5..7
      send_frame(32'd5, 16'd64, 0, -1, -1, 0, 1'b0);
      send_frame(32'd6, 16'd64, 0, -1, -1, 0, 1'b0);
      send_frame(32'd7, 16'd64, 0, -1, -1, 0, 1'b0);
      check_stats("good3", 32'd3, 32'd0, 4'b0000, 1'b1);

      pulse_clear();
      check_stats("clear", 32'd0, 32'd0, 4'b0000, 1'b0);

      // 13-byte frame: last keep 1F is legal, 3F is a KEEP error
      send_frame(32'd10, 16'd13, 0, 8'h1F, -1, 0, 1'b0);
      check_stats("len13_ok", 32'd1, 32'd0, 4'b0000, 1'b1);
      send_frame(32'd11, 16'd13, 0, 8'h3F, -1, 0, 1'b0);
      check_stats("len13_keep", 32'd2, 32'd1, 4'b1000, 1'b0);

      // Sequence gap 1,2,4,5 counts once
      pulse_clear();
      send_frame(32'd1, 16'd8, 0, -1, -1, 0, 1'b0);
      send_frame(32'd2, 16'd8, 0, -1, -1, 0, 1'b0);
      send_frame(32'd4, 16'd8, 0, -1, -1, 0, 1'b0);
      send_frame(32'd5, 16'd8, 0, -1, -1, 0, 1'b0);
      check_stats("seq_gap", 32'd4, 32'd1, 4'b0100, 1'b0);

      // Early/late tlast and corrupted payload byte
      pulse_clear();
      send_frame(32'd20, 16'd16, 3, -1, -1, 0, 1'b0);
      check_stats("len_extra_beat", 32'd1, 32'd1, 4'b0010, 1'b0);
      send_frame(32'd21, 16'd16, 0, -1, 1, 0, 1'b0);
      check_stats("data_corrupt", 32'd2, 32'd2, 4'b0011, 1'b0);

      // Illegal lengths: zero and one byte over the maximum
      pulse_clear();
      send_frame(32'd30, 16'd0, 0, -1, -1, 0, 1'b0);
      check_stats("len_zero", 32'd1, 32'd1, 4'b0010, 1'b0);
      send_frame(32'd31, 16'd1473, 0, 8'h01, -1, 0, 1'b0);
      check_stats("len_over", 32'd2, 32'd2, 4'b0010, 1'b0);

      // Clear coinciding with CHECK discards the frame and unlocks the sequence
      send_frame(32'd50, 16'd8, 0, -1, -1, 0, 1'b1);
      check_stats("clear_at_check", 32'd0, 32'd0, 4'b0000, 1'b0);
      send_frame(32'd77, 16'd8, 0, -1, -1, 0, 1'b0);
      check_stats("unlocked", 32'd1, 32'd0, 4'b0000, 1'b1);

      // Reset mid-frame abandons it
      push_beat({32'd200, 32'd0}, 8'hFF, 1'b0, 16'd64);
      push_beat({32'd200, 32'd1}, 8'hFF, 1'b0, 16'd64);
      push_beat({32'd200, 32'd2}, 8'hFF, 1'b0, 16'd64);
      #2 i_rst = 1'b0;
      #1;
      check_output("midrst.tready", s0.tready, 64'd0);
      check_output("midrst.frame_cnt", frame_cnt0, 64'd0);
      @(negedge i_clk);
      i_rst = 1'b1;
      @(negedge i_clk);
      send_frame(32'd9, 16'd24, 0, -1, -1, 0, 1'b0);
      check_stats("after_midrst", 32'd1, 32'd0, 4'b0000, 1'b1);

      // Throttled instance with tvalid held high for a 12-beat frame
      k4 = 0;
      for (int i = 0; i < 15; i++) begin
         if (k4 < 12) begin
            s4.tdata  = {32'd1000, 32'(k4)};
            s4.tkeep  = 8'hFF;
            s4.tlast  = (k4 == 11);
            s4.tuser  = {16'h0000, 16'd96};
            s4.tvalid = 1'b1;
         end else begin
            s4.tvalid = 1'b0;
            s4.tlast  = 1'b0;
         end
         ready_seen[14-i] = s4.tready;
         if (s4.tready && s4.tvalid) k4++;
         @(negedge i_clk);
      end
      s4.tvalid = 1'b0;
      @(negedge i_clk);
      check_output("thr.ready_pattern", ready_seen, 64'b111101111011110);
      check_output("thr.beats", k4, 64'd12);
      check_output("thr.frame_cnt", frame_cnt4, 64'd1);
      check_output("thr.err_cnt", err_cnt4, 64'd0);
      check_output("thr.flags", flags4, 64'd0);
      check_output("thr.pass", pass4, 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/axis_check_module.md
AXIS_CHECK_MODULE -- requirements
Module: AXIS_check_module

Interface
REQ-001 SHALL provide parameter P_MAX_LEN, default 16'd1472; the maximum legal frame length in bytes.
REQ-002 SHALL provide parameter P_READY_PERIOD, default 0; when nonzero, ready drops for 1 cycle after every P_READY_PERIOD accepted beats; 0 means always ready.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock (XGMII user clock domain).
REQ-004 SHALL have port i_rst, input, 1 bit: asynchronous, active-low reset; 0 resets the block.
REQ-005 SHALL have port s_axis_tdata, input, 64 bits: payload word.
REQ-006 SHALL have port s_axis_tuser, input, 32 bits: bits [15:0] carry the frame byte length, sampled on the first beat; bits [31:16] are ignored.
REQ-007 SHALL have port s_axis_tkeep, input, 8 bits: byte enables, LSB-aligned.
REQ-008 SHALL have port s_axis_tlast, input, 1 bit: marks the final beat of a frame.
REQ-009 SHALL have port s_axis_tvalid, input, 1 bit: beat valid.
REQ-010 SHALL have port s_axis_tready, output, 1 bit: sink ready.
REQ-011 SHALL have port i_clear, input, 1 bit: synchronous clear of counters and flags.
REQ-012 SHALL have port o_frame_cnt, output, 32 bits: count of frames received.
REQ-013 SHALL have port o_err_cnt, output, 32 bits: count of frames with at least one error; saturates at 32'hFFFF_FFFF.
REQ-014 SHALL have port o_err_flags, output, 4 bits: sticky flags {KEEP,SEQ,LEN,DATA} = bits [3:0].
REQ-015 SHALL have port o_pass, output, 1 bit: high when o_frame_cnt is nonzero and o_err_flags equals 0.

Function
REQ-016 SHALL accept a beat only when s_axis_tvalid and s_axis_tready are both 1.
REQ-017 SHALL implement an FSM with states IDLE, DATA and CHECK.
 - IDLE: the first handshake latches the length L and the sequence number from tdata[63:32], then moves to DATA, or to CHECK if tlast=1.
 - DATA: each handshake increments the beat index k; the tlast beat moves to CHECK.
 - CHECK: lasts one cycle, updates counters and flags, then returns to IDLE.
REQ-018 SHALL define the expected word k (0-based) as {seq[31:0], k[31:0]}, comparing only the bytes enabled by tkeep; any mismatch sets DATA.
REQ-019 SHALL compute the expected beat count as ceil(L/8); LEN SHALL set if tlast arrives at a different beat, or if L=0 or L>P_MAX_LEN.
REQ-020 SHALL require tkeep=8'hFF on non-last beats; on the last beat tkeep SHALL equal (1<<r)-1, where r=L mod 8, or 8'hFF when r=0; any violation sets KEEP.
REQ-021 SHALL lock the sequence on the first frame after reset or i_clear; each later frame SHALL require seq = previous seq + 1 (mod 2^32), and a mismatch sets SEQ.
REQ-022 SHALL re-arm the expected sequence to the received seq + 1 after a SEQ error, so a single gap is counted once.
REQ-023 SHALL, in CHECK, increment o_frame_cnt by 1 (wrapping), and increment o_err_cnt (saturating) if any per-frame error occurred; per-frame errors SHALL OR into o_err_flags.
REQ-024 SHALL make the counters and flags visible on the cycle after CHECK, i.e. 2 cycles after the tlast handshake.
REQ-025 SHALL hold s_axis_tready at 0 during CHECK and during P_READY_PERIOD gap cycles, and at 1 otherwise.
REQ-026 SHALL treat a beat count exceeding ceil(P_MAX_LEN/8)+1 without tlast as a LEN error, then discard beats until tlast; the beat counter SHALL NOT wrap.
REQ-027 SHALL give i_clear priority over a simultaneous CHECK update: counters and flags go to 0, the in-flight frame is still checked, but its result is discarded and the sequence is unlocked.

Reset
REQ-028 SHALL, while i_rst=0, asynchronously force: FSM to IDLE; s_axis_tready=0; o_frame_cnt=0; o_err_cnt=0; o_err_flags=4'b0000; o_pass=0; sequence unlocked.
REQ-029 SHALL raise s_axis_tready on the first clock edge after i_rst deasserts.
REQ-030 SHALL abandon any partially received frame when reset asserts mid-frame, without counting it.

Verification
REQ-031 SHALL verify: 3 frames, L=64, seq 5,6,7, correct pattern -> o_frame_cnt=3, o_err_cnt=0, o_pass=1.
REQ-032 SHALL verify: L=13 with last tkeep 8'h1F -> no error; the same frame with last tkeep 8'h3F -> o_err_flags=4'b1000 and o_err_cnt=1.
REQ-033 SHALL verify: seq 1,2,4,5 -> o_err_cnt=1, SEQ set, o_frame_cnt=4.
REQ-034 SHALL verify: L=16 with tlast on beat 3 -> LEN set; byte 0 of word 1 corrupted in a separate frame -> DATA set; o_err_cnt=2.
REQ-035 SHALL verify: P_READY_PERIOD=4 with tvalid held high -> tready low for 1 cycle every 4 beats, and no data loss with o_err_cnt=0.
REQ-036 SHALL verify: i_rst low mid-frame, then 1 good frame with any seq -> o_frame_cnt=1 and o_err_flags=0.
